// File: rtl/mul_seq.sv
// Sequential N x N unsigned shift-add multiplier that drives an external
// combinational ALU (ADD mode) and folds its R/carry back into the partial product.
module mul_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [1:0]     alu_op,
    output logic           alu_l,
    input  logic [N-1:0]   alu_r,
    input  logic           alu_carry,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     phi_q, phi_d;
    logic [N-1:0]     plo_q, plo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   prod_q, prod_d;
    logic [2*N-1:0]   shifted;

    // {carry, R, P_lo} shifted right by one; the dropped bit is the consumed multiplier bit
    assign shifted = {alu_carry, alu_r, plo_q[N-1:1]};

    assign alu_op  = 2'b00;
    assign alu_l   = 1'b0;
    assign alu_a   = phi_q;
    assign alu_b   = plo_q[0] ? m_q : '0;
    assign product = prod_q;
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = mcand;
                    phi_d   = '0;
                    plo_d   = mplier;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                {phi_d, plo_d} = shifted;
                cnt_d          = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    prod_d  = shifted;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately not sampled here; a held start re-arms from IDLE
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: models the external combinational ALU and checks products
// through a scoreboard queue filled at start and drained at each done pulse.
module tb_mul_seq;

    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic [N-1:0]   mcand;
    logic [N-1:0]   mplier;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [1:0]     alu_op;
    logic           alu_l;
    logic [N-1:0]   alu_r;
    logic           alu_carry;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    logic [N:0]     alu_sum;
    logic [7:0]     exp_q[$];
    int             checks;
    int             errors;

    // run_op observations
    int             last_busy;
    int             last_wait;
    logic [15:0]    last_bseq;
    logic           last_opbad;

    assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_r     = alu_sum[N-1:0];
    assign alu_carry = alu_sum[N];

    mul_seq #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mcand     (mcand),
        .mplier    (mplier),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_l     (alu_l),
        .alu_r     (alu_r),
        .alu_carry (alu_carry),
        .product   (product),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        return {4'b0, a} * {4'b0, b};
    endfunction

    // One start pulse, then follow the operation until done or a cycle bound.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        exp_q.push_back(ref_mul(a, b));
        @(negedge clk);
        start      = 1'b0;
        last_busy  = 0;
        last_wait  = 0;
        last_bseq  = '0;
        last_opbad = 1'b0;
        while (done !== 1'b1 && last_wait < 20) begin
            if (busy === 1'b1) begin
                last_busy = last_busy + 1;
                last_bseq = {last_bseq[11:0], alu_b};
            end
            if (alu_op !== 2'b00 || alu_l !== 1'b0) last_opbad = 1'b1;
            @(negedge clk);
            last_wait = last_wait + 1;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (product !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: product=%h busy=%b done=%b, required 00/0/0", product, busy, done);
        end
        checks++;
        if (alu_op !== 2'b00 || alu_l !== 1'b0 || alu_a !== 4'h0 || alu_b !== 4'h0) begin
            errors++;
            $display("FAIL reset_alu: op=%b l=%b a=%h b=%h, required 00/0/0/0", alu_op, alu_l, alu_a, alu_b);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_max();
        logic [7:0] e;
        run_op(4'hF, 4'hF);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL max_timeout: done=%b after %0d cycles, required 1", done, last_wait);
        end
        checks++;
        if (last_busy != 4 || last_wait != 4) begin
            errors++;
            $display("FAIL max_latency: busy cycles=%0d wait=%0d, required 4/4", last_busy, last_wait);
        end
        e = exp_q.pop_front();
        checks++;
        if (product !== e) begin
            errors++;
            $display("FAIL max_product: got %h, required %h", product, e);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL max_done_pulse: done=%b busy=%b one cycle later, required 0/0", done, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (product !== 8'hE1) begin
            errors++;
            $display("FAIL max_hold: product=%h, required e1", product);
        end
    endtask

    task automatic test_alu_seq();
        logic [7:0] e;
        run_op(4'd3, 4'd5);
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || product !== e) begin
            errors++;
            $display("FAIL mul_3x5: done=%b product=%h, required 1/%h", done, product, e);
        end
        checks++;
        if (last_bseq !== 16'h3030) begin
            errors++;
            $display("FAIL alu_b_seq: got %h, required 3030", last_bseq);
        end
        checks++;
        if (last_opbad !== 1'b0) begin
            errors++;
            $display("FAIL alu_op_const: op/l changed during run, required 00/0");
        end
    endtask

    task automatic test_zero();
        logic [7:0] e;
        run_op(4'hA, 4'h0);
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || product !== e || last_busy != 4) begin
            errors++;
            $display("FAIL zero_mplier: done=%b product=%h busy=%0d, required 1/%h/4", done, product, last_busy, e);
        end
        run_op(4'h0, 4'hB);
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || product !== e || last_busy != 4) begin
            errors++;
            $display("FAIL zero_mcand: done=%b product=%h busy=%0d, required 1/%h/4", done, product, last_busy, e);
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] e;
        int pulses;
        @(negedge clk);
        mcand  = 4'h7;
        mplier = 4'h9;
        start  = 1'b1;
        exp_q.push_back(ref_mul(4'h7, 4'h9));
        @(negedge clk);
        mcand  = 4'h1;
        mplier = 4'h1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (product !== e) begin
                        errors++;
                        $display("FAIL ignore_product: got %h, required %h", product, e);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL ignore_pulses: saw %0d done pulses, required 1", pulses);
        end
    endtask

    task automatic test_reset_midrun();
        logic [7:0] e;
        int pulses;
        @(negedge clk);
        mcand  = 4'hF;
        mplier = 4'hF;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b product=%h, required 0/0/00", busy, done, product);
        end
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_quiet: saw %0d busy/done cycles after abort, required 0", pulses);
        end
        run_op(4'h2, 4'h6);
        e = exp_q.pop_front();
        checks++;
        if (done !== 1'b1 || product !== e) begin
            errors++;
            $display("FAIL after_abort: done=%b product=%h, required 1/%h", done, product, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        int n;
        @(negedge clk);
        mcand  = 4'h0;
        mplier = 4'h0;
        start  = 1'b1;
        exp_q.push_back(ref_mul(4'h0, 4'h0));
        for (int k = 0; k < 256; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done !== 1'b1 && n < 20);
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_timeout: pair %0d no done within %0d cycles", k, n);
            end
            e = exp_q.pop_front();
            checks++;
            if (product !== e) begin
                errors++;
                $display("FAIL b2b_product: pair %0d got %h, required %h", k, product, e);
            end
            if (k > 0) begin
                checks++;
                if (n != 6) begin
                    errors++;
                    $display("FAIL b2b_period: pair %0d period %0d, required 6", k, n);
                end
            end
            if (k < 255) begin
                mcand  = 4'((k + 1) >> 4);
                mplier = 4'((k + 1) & 15);
                exp_q.push_back(ref_mul(4'((k + 1) >> 4), 4'((k + 1) & 15)));
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_max();
        test_alu_seq();
        test_zero();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Sequential 4x4 unsigned shift-add multiplier that acts as the initiator (driver) of the 4-bit ALU interface.
- Presents operands and op-select to an external ALU instance and consumes its R/carry result in the same cycle.
- Builds an 8-bit product over N cycles.
- Sits beside the ALU in the datapath; the ALU stays purely combinational and this block supplies all sequencing.

Parameters:
- N, 4, operand width. Must equal the ALU width (4). Iteration count = N.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- mcand  input  N  multiplicand, captured on accepted start
- mplier  input  N  multiplier, captured on accepted start
- alu_a  output  N  ALU operand A
- alu_b  output  N  ALU operand B
- alu_op  output  2  ALU ALUOp select
- alu_l  output  1  ALU L (logic/arith) select
- alu_r  input  N  ALU result R
- alu_carry  input  1  ALU carry out
- product  output  2N  result; held until next accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when product becomes valid

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; M, P_hi, P_lo, cnt cleared to 0; product=0, busy=0, done=0.
- ALU driving:
  - alu_op=2'b00 and alu_l=0 (ADD: R = A + B, carry = bit N) at all times, including during reset.
  - alu_a=P_hi.
  - alu_b = P_lo[0] ? M : 0, in every state.
  - Combinational loop alu_a/alu_b -> alu_r/alu_carry resolves within one cycle; no registers on the ALU path.
- States:
  - IDLE: busy=0. On start=1: M<=mcand, P_hi<=0, P_lo<=mplier, cnt<=0, go RUN. start=0: stay.
  - RUN: busy=1. Each cycle:
    - {P_hi,P_lo} <= {alu_carry, alu_r, P_lo[N-1:1]}, i.e. a 2N+1-bit value {carry,R,P_lo} shifted right 1.
    - cnt<=cnt+1.
    - When cnt==N-1: go DONE, product <= the shifted {alu_carry, alu_r, P_lo[N-1:1]}.
  - DONE: busy=0, done=1 for exactly this cycle, then IDLE unconditionally.
- Start handling:
  - start in RUN or DONE is ignored and not queued.
  - start held high continuously restarts from IDLE every N+2 cycles.
- Latency: start accepted at edge 0 -> RUN for N cycles -> product valid and done=1 in cycle N+1 after acceptance.
- Operands: mcand/mplier are read only on the accepting edge; later changes have no effect on the current operation.
- Width: product = mcand*mplier exactly, unsigned, max (2^N-1)^2 = 225 for N=4. No overflow possible; carry is absorbed into P_hi.
- product updates only on the DONE transition; it holds otherwise, including during RUN.
- Reset mid-RUN: immediate abort. All state and outputs return to reset values; no done pulse.
- cnt width: clog2(N)+1 bits; no wrap within an operation.

Test Plan:
- Reset, start with mcand=4'hF, mplier=4'hF -> busy high 4 cycles, done pulse in 5th cycle after accept, product=8'hE1 (225), held until next start.
- mcand=4'd3, mplier=4'd5 -> product=8'h0F. Check alu_b sequence per RUN cycle: 3,0,3,0. alu_op=00 and alu_l=0 throughout.
- mcand=4'hA, mplier=0 and mcand=0, mplier=4'hB -> product=8'h00 both; done still pulses after 4 RUN cycles.
- start=1 during RUN with mcand=1, mplier=1 -> ignored; first result 4'h7*4'h9=8'h3F unaffected. Exactly one done pulse.
- Assert reset on the 2nd RUN cycle of 4'hF*4'hF -> busy=0, done=0, product=0 asynchronously. A following 4'h2*4'h6 -> product=8'h0C.
- Exhaustive: all 256 operand pairs back-to-back, start held high -> each product equals the reference multiply; done period = 6 cycles.
